// File: rtl/md_unit_pkg.sv
// Shared opcode constants and default timing for the HI/LO multiply/divide unit.
// These constants sit alongside the decoder's other opcode definitions.
package md_unit_pkg;

    // md_cop: operation select
    localparam logic [3:0] MDCM    = 4'h0;
    localparam logic [3:0] MDCMU   = 4'h1;
    localparam logic [3:0] MDCD    = 4'h2;
    localparam logic [3:0] MDCDU   = 4'h3;

    // md_wop: move-to select
    localparam logic [3:0] MDTHI   = 4'h0;
    localparam logic [3:0] MDTLO   = 4'h1;

    localparam logic [3:0] MD_NONE = 4'hF;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int MD_CNT_W        = 8;

    function automatic logic md_is_mul(input logic [3:0] cop);
        return (cop == MDCM) || (cop == MDCMU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] cop);
        return (cop == MDCD) || (cop == MDCDU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Pipeline <-> mult/div unit signal bundle.
// master = E-stage pipeline side, slave = md_unit.
interface md_unit_if;
    logic        md_start;
    logic [3:0]  md_cop;
    logic [3:0]  md_wop;
    logic        md_rop;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic [31:0] md_rdata;

    modport master (
        output md_start, md_cop, md_wop, md_rop, rs_data, rt_data, flush,
        input  busy, md_rdata
    );

    modport slave (
        input  md_start, md_cop, md_wop, md_rop, rs_data, rt_data, flush,
        output busy, md_rdata
    );
endinterface

// File: rtl/md_arith.sv
// Purpose: combinational mult/multu/div/divu result for the HI/LO unit.
// Latency: none (pure combinational); timing is modelled by the owner's counter.
// Backpressure: none; valid=0 flags divide by zero so the owner skips commit.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [3:0]  cop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] dsr_s;
    logic        [31:0] dsr_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Substitute a divisor of 1 for /0 and for the -2^31 / -1 overflow case:
    // x/1 yields exactly the required 0x80000000 quotient with zero remainder.
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign dsr_s    = (div_zero || div_ovf) ? 32'd1 : b;
    assign dsr_u    = div_zero ? 32'd1 : b;

    assign quo_s = $signed(a) / $signed(dsr_s);
    assign rem_s = $signed(a) % $signed(dsr_s);
    assign quo_u = a / dsr_u;
    assign rem_u = a % dsr_u;

    always_comb begin
        hi    = 32'd0;
        lo    = 32'd0;
        valid = 1'b0;
        case (cop)
            MDCM: begin
                {hi, lo} = prod_s;
                valid    = 1'b1;
            end
            MDCMU: begin
                {hi, lo} = prod_u;
                valid    = 1'b1;
            end
            MDCD: begin
                lo    = quo_s;
                hi    = rem_s;
                valid = !div_zero;
            end
            MDCDU: begin
                lo    = quo_u;
                hi    = rem_u;
                valid = !div_zero;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// Purpose: HI/LO registers with fixed-latency mult/div and move-to writes.
// Latency: result commits MULT_CYCLES/DIV_CYCLES edges after the accepting edge; mthi/mtlo immediate.
// Backpressure: busy high while counting; starts/writes during busy or flush are dropped (hazard unit stalls).
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    md_unit_if.slave   md
);
    logic [31:0]         hi_q;
    logic [31:0]         lo_q;
    logic [31:0]         hi_n;
    logic [31:0]         lo_n;
    logic                res_vld;
    logic [MD_CNT_W-1:0] cnt;

    logic [31:0] ar_hi;
    logic [31:0] ar_lo;
    logic        ar_valid;
    logic        busy;
    logic        accept;
    logic        wr_ok;

    md_arith u_arith (
        .cop   (md.md_cop),
        .a     (md.rs_data),
        .b     (md.rt_data),
        .hi    (ar_hi),
        .lo    (ar_lo),
        .valid (ar_valid)
    );

    assign busy   = (cnt != '0);
    assign wr_ok  = !busy && !md.flush;
    assign accept = md.md_start && wr_ok && (md_is_mul(md.md_cop) || md_is_div(md.md_cop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n    <= 32'd0;
            lo_n    <= 32'd0;
            res_vld <= 1'b0;
            cnt     <= '0;
        end else if (cnt == MD_CNT_W'(1)) begin
            cnt <= '0;
            // Divide by zero runs the full duration but leaves HI/LO untouched.
            if (res_vld) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
            end
        end else if (busy) begin
            cnt <= cnt - MD_CNT_W'(1);
        end else begin
            if (accept) begin
                cnt     <= md_is_mul(md.md_cop) ? MD_CNT_W'(MULT_CYCLES) : MD_CNT_W'(DIV_CYCLES);
                hi_n    <= ar_hi;
                lo_n    <= ar_lo;
                res_vld <= ar_valid;
            end
            if (wr_ok && (md.md_wop == MDTHI)) begin
                hi_q <= md.rs_data;
            end else if (wr_ok && (md.md_wop == MDTLO)) begin
                lo_q <= md.rs_data;
            end
        end
    end

    assign md.busy     = busy;
    assign md.md_rdata = md.md_rop ? lo_q : hi_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed + random bench for md_unit against an edge-count based reference model.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    md_unit_if md_if();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: architectural values plus the edge number at which
    // the pending result is due; busy means "due edge not yet reached".
    int          edge_no  = 0;
    int          done_edge = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    logic        m_pv = 0;

    logic [3:0] cop_tab [7] = '{MDCM, MDCMU, MDCD, MDCDU, MD_NONE, 4'h5, 4'h8};
    logic [3:0] wop_tab [6] = '{MDTHI, MDTLO, MD_NONE, MD_NONE, MD_NONE, 4'h7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [3:0] cop, input logic [3:0] wop,
                         input logic [31:0] rs, input logic [31:0] rt, input logic fl);
        md_if.md_start = st;
        md_if.md_cop   = cop;
        md_if.md_wop   = wop;
        md_if.rs_data  = rs;
        md_if.rt_data  = rt;
        md_if.flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, MD_NONE, MD_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic ref_result(input logic [3:0] cop, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo, output logic v);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        int              ia, ib;
        hi = 0; lo = 0; v = 1'b1;
        case (cop)
            MDCM: begin
                sa = $signed(a); sb = $signed(b); ps = sa * sb;
                hi = ps[63:32]; lo = ps[31:0];
            end
            MDCMU: begin
                ua = a; ub = b; pu = ua * ub;
                hi = pu[63:32]; lo = pu[31:0];
            end
            MDCD: begin
                if (b == 0) v = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    ia = a; ib = b; lo = ia / ib; hi = ia % ib;
                end
            end
            default: begin
                if (b == 0) v = 1'b0;
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        md_if.md_rop = 1'b0;
        #1 hi = md_if.md_rdata;
        md_if.md_rop = 1'b1;
        #1 lo = md_if.md_rdata;
    endtask

    // One clock edge: predict from the inputs in place before the edge, then compare.
    task automatic tick(input string tag);
        logic [3:0]  cop, wop;
        logic [31:0] rs, rt, nhi, nlo, rh, rl;
        logic        st, fl, nv, idle_now, acc;
        int          e;
        st = md_if.md_start; cop = md_if.md_cop; wop = md_if.md_wop;
        rs = md_if.rs_data;  rt = md_if.rt_data; fl = md_if.flush;
        e        = edge_no + 1;
        idle_now = (edge_no >= done_edge);
        acc      = st && !fl && idle_now && (cop inside {MDCM, MDCMU, MDCD, MDCDU});
        nhi = 0; nlo = 0; nv = 0;
        if (acc) ref_result(cop, rs, rt, nhi, nlo, nv);
        @(posedge clk);
        #1;
        edge_no = e;
        if (e == done_edge && m_pv) begin
            m_hi = m_phi; m_lo = m_plo;
        end
        if (acc) begin
            done_edge = e + ((cop == MDCM || cop == MDCMU) ? 5 : 10);
            m_phi = nhi; m_plo = nlo; m_pv = nv;
        end
        if (idle_now && !fl && wop == MDTHI) m_hi = rs;
        if (idle_now && !fl && wop == MDTLO) m_lo = rs;
        chk({tag, "_busy"}, {31'd0, md_if.busy}, {31'd0, edge_no < done_edge});
        read_hl(rh, rl);
        chk({tag, "_hi"}, rh, m_hi);
        chk({tag, "_lo"}, rl, m_lo);
    endtask

    task automatic run_op(input string tag, input logic [3:0] cop, input logic [31:0] rs,
                          input logic [31:0] rt, output int len);
        drive(1'b1, cop, MD_NONE, rs, rt, 1'b0);
        tick(tag);
        idle();
        len = 0;
        while (md_if.busy === 1'b1 && len < 100) begin
            len++;
            tick(tag);
        end
    endtask

    initial begin
        logic [31:0] rh, rl;
        int          len;

        idle();
        md_if.md_rop = 1'b0;
        reset_n = 1'b0;
        #3;
        chk("reset_busy", {31'd0, md_if.busy}, 32'd0);
        read_hl(rh, rl);
        chk("reset_hi", rh, 32'd0);
        chk("reset_lo", rl, 32'd0);
        #6 reset_n = 1'b1;

        drive(1'b0, MD_NONE, MDTHI, 32'h1111, 32'd0, 1'b0); tick("mthi");
        drive(1'b0, MD_NONE, MDTLO, 32'h2222, 32'd0, 1'b0); tick("mtlo");
        read_hl(rh, rl);
        chk("mthi_val", rh, 32'h1111);
        chk("mtlo_val", rl, 32'h2222);

        run_op("mult", MDCM, 32'hFFFF_FFFF, 32'd2, len);
        chk("mult_len", len, 5);
        read_hl(rh, rl);
        chk("mult_hi_val", rh, 32'hFFFF_FFFF);
        chk("mult_lo_val", rl, 32'hFFFF_FFFE);

        run_op("multu", MDCMU, 32'hFFFF_FFFF, 32'd2, len);
        chk("multu_len", len, 5);
        read_hl(rh, rl);
        chk("multu_hi_val", rh, 32'h0000_0001);
        chk("multu_lo_val", rl, 32'hFFFF_FFFE);

        run_op("div", MDCD, 32'hFFFF_FFF9, 32'd2, len);
        chk("div_len", len, 10);
        read_hl(rh, rl);
        chk("div_hi_val", rh, 32'hFFFF_FFFF);
        chk("div_lo_val", rl, 32'hFFFF_FFFD);

        run_op("divu0", MDCDU, 32'd7, 32'd0, len);
        chk("divu0_len", len, 10);
        read_hl(rh, rl);
        chk("divu0_hi_val", rh, 32'hFFFF_FFFF);
        chk("divu0_lo_val", rl, 32'hFFFF_FFFD);

        run_op("divovf", MDCD, 32'h8000_0000, 32'hFFFF_FFFF, len);
        read_hl(rh, rl);
        chk("divovf_hi_val", rh, 32'd0);
        chk("divovf_lo_val", rl, 32'h8000_0000);

        // Stalled mthi and second start during busy must be dropped.
        drive(1'b1, MDCM, MD_NONE, 32'd3, 32'd4, 1'b0); tick("hz_start");
        drive(1'b0, MD_NONE, MDTHI, 32'h55, 32'd0, 1'b0); tick("hz_mthi");
        drive(1'b1, MDCM, MD_NONE, 32'd5, 32'd5, 1'b0); tick("hz_start2");
        idle();
        len = 0;
        while (md_if.busy === 1'b1 && len < 100) begin len++; tick("hz_wait"); end
        chk("hz_len", len, 3);
        read_hl(rh, rl);
        chk("hz_hi_val", rh, 32'd0);
        chk("hz_lo_val", rl, 32'd12);

        drive(1'b1, MDCM, MD_NONE, 32'd7, 32'd7, 1'b1); tick("fl_start");
        chk("fl_start_busy", {31'd0, md_if.busy}, 32'd0);
        drive(1'b0, MD_NONE, MDTLO, 32'hAB, 32'd0, 1'b1); tick("fl_mtlo");
        read_hl(rh, rl);
        chk("fl_mtlo_val", rl, 32'd12);
        drive(1'b0, MD_NONE, MDTLO, 32'hAB, 32'd0, 1'b0); tick("mtlo_ab");
        read_hl(rh, rl);
        chk("mtlo_ab_val", rl, 32'hAB);

        drive(1'b1, MD_NONE, MD_NONE, 32'd9, 32'd9, 1'b0); tick("cop_none");
        drive(1'b1, 4'h7, 4'h9, 32'd9, 32'd9, 1'b0); tick("cop_undef");

        // Asynchronous reset in the middle of a divide.
        drive(1'b1, MDCD, MD_NONE, 32'd100, 32'd7, 1'b0); tick("rst_div");
        idle();
        for (int i = 0; i < 3; i++) tick("rst_div_run");
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy_low", {31'd0, md_if.busy}, 32'd0);
        chk("arst_lo_low", md_if.md_rdata, 32'd0);
        reset_n = 1'b1;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pv = 0; done_edge = edge_no;
        chk("arst_busy", {31'd0, md_if.busy}, 32'd0);
        read_hl(rh, rl);
        chk("arst_hi", rh, 32'd0);
        chk("arst_lo", rl, 32'd0);
        for (int i = 0; i < 12; i++) tick("post_rst");
        read_hl(rh, rl);
        chk("no_commit_hi", rh, 32'd0);
        chk("no_commit_lo", rl, 32'd0);

        run_op("post_multu", MDCMU, 32'h0001_0000, 32'h0001_0000, len);
        chk("post_multu_len", len, 5);
        read_hl(rh, rl);
        chk("post_multu_hi", rh, 32'd1);
        chk("post_multu_lo", rl, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] rs, rt;
            rs = $urandom;
            rt = ($urandom_range(4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(15) == 0) begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
            if ($urandom_range(3) == 0) rt = $urandom_range(20);
            drive($urandom_range(2) == 0, cop_tab[$urandom_range(6)], wop_tab[$urandom_range(5)],
                  rs, rt, $urandom_range(5) == 0);
            tick("rand");
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
